// File: rtl/dmem_responder_pkg.sv
// dmem_pkg: MMIO offsets, CON_STAT bit layout and region select shared by dmem_responder.
package dmem_pkg;
  localparam logic [3:0] OFF_CON_TX   = 4'h0;
  localparam logic [3:0] OFF_CON_STAT = 4'h4;
  localparam logic [3:0] OFF_MTIME    = 4'h8;
  localparam logic [3:0] OFF_MTIMECMP = 4'hC;
  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_OVF   = 2;
  localparam int STAT_LEVEL = 3;
  localparam int LEVEL_W    = 5;
  typedef enum logic [1:0] {SEL_RAM, SEL_MMIO, SEL_NONE} sel_e;
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: core load/store port; the core is master, the responder is slave.
interface dmem_responder_if;
  logic        MemWrite;
  logic [31:0] dAddr;
  logic [31:0] WriteData;
  logic [31:0] dMemData;
  modport master (output MemWrite, dAddr, WriteData, input dMemData);
  modport slave (input MemWrite, dAddr, WriteData, output dMemData);
endinterface

// File: rtl/dmem_responder_sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count; push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (AW + 1)'(DEPTH);
  assign empty = cnt == '0;
  assign level = cnt;
  assign dout = mem[rp];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder with word RAM, console TX FIFO and MMIO status.
// Defining DMEM_TIMER_EN adds the mtime/mtimecmp cycle timer and its compare interrupt.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          RAM_WORDS  = 1024,
  parameter logic [31:0] RAM_BASE   = 32'h0000_0000,
  parameter logic [31:0] MMIO_BASE  = 32'h1000_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  dmem_responder_if.slave        bus,
  output logic                   con_valid,
  output logic [7:0]             con_data,
  input  logic                   con_ready,
  output logic                   timer_irq,
  output logic                   bus_err
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
`ifdef DMEM_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif
  logic [31:0] ram [RAM_WORDS];
  logic [31:0] ram_off, mmio_off, stat, mtime_rd, cmp_rd;
  logic [3:0] off;
  logic mmio_hit, timer_off, wr_mmio, tx_wr, full, empty, overflow;
  logic [LW-1:0] level;
  logic [7:0] head;
  sel_e sel;
  always_comb begin
    ram_off = bus.dAddr - RAM_BASE;
    mmio_off = bus.dAddr - MMIO_BASE;
    off = {mmio_off[3:2], 2'b00};
    timer_off = off == OFF_MTIME || off == OFF_MTIMECMP;
    mmio_hit = mmio_off < 32'd16 && (TIMER_EN || !timer_off);
    sel = ram_off < 32'(RAM_WORDS * 4) ? SEL_RAM : mmio_hit ? SEL_MMIO : SEL_NONE;
    wr_mmio = bus.MemWrite && sel == SEL_MMIO;
    tx_wr = wr_mmio && off == OFF_CON_TX;
  end
  // read-during-write returns the old word: the read is combinational, the write lands on the edge
  always_ff @(posedge clk)
    if (bus.MemWrite && sel == SEL_RAM) ram[ram_off[AW+1:2]] <= bus.WriteData;
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (tx_wr),
    .pop   (con_valid && con_ready),
    .din   (bus.WriteData[7:0]),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );
  assign con_valid = !empty;
  assign con_data = empty ? 8'h00 : head;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      overflow <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      if (tx_wr && full) overflow <= 1'b1;
      else if (wr_mmio && off == OFF_CON_STAT && bus.WriteData[STAT_OVF]) overflow <= 1'b0;
      if (sel == SEL_NONE) bus_err <= 1'b1;
    end
`ifdef DMEM_TIMER_EN
  logic [31:0] mtime, mtimecmp;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      mtime <= '0;
      mtimecmp <= '1;
      timer_irq <= 1'b0;
    end else begin
      mtime <= wr_mmio && off == OFF_MTIME ? bus.WriteData : mtime + 32'd1;
      if (wr_mmio && off == OFF_MTIMECMP) mtimecmp <= bus.WriteData;
      timer_irq <= mtime >= mtimecmp;
    end
  assign mtime_rd = mtime;
  assign cmp_rd = mtimecmp;
`else
  assign timer_irq = 1'b0;
  assign mtime_rd = '0;
  assign cmp_rd = '0;
`endif
  always_comb begin
    stat = '0;
    stat[STAT_EMPTY] = empty;
    stat[STAT_FULL] = full;
    stat[STAT_OVF] = overflow;
    stat[STAT_LEVEL +: LEVEL_W] = LEVEL_W'(level);
  end
  assign bus.dMemData = sel == SEL_RAM ? ram[ram_off[AW+1:2]] :
                        sel == SEL_NONE ? '0 :
                        off == OFF_CON_STAT ? stat :
                        off == OFF_MTIME ? mtime_rd :
                        off == OFF_MTIMECMP ? cmp_rd : '0;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and random traffic checked against a queue/array reference model.
module tb_dmem_responder;
  localparam logic [31:0] TX = 32'h1000_0000;
  localparam logic [31:0] ST = 32'h1000_0004;
  localparam logic [31:0] MT = 32'h1000_0008;
  localparam logic [31:0] MC = 32'h1000_000C;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic con_ready = 1'b0;
  logic con_valid, timer_irq, bus_err;
  logic [7:0] con_data;
  dmem_responder_if bus();
  dmem_responder dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .con_valid (con_valid),
    .con_data  (con_data),
    .con_ready (con_ready),
    .timer_irq (timer_irq),
    .bus_err   (bus_err)
  );
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] m_ram [16];
  bit m_known [16];
  byte unsigned q[$];
  bit m_ovf, m_err, m_irq;
  logic [31:0] m_time, m_cmp;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  // 0 = RAM, 1 = mapped MMIO register, 2 = unmapped
  function automatic int region(input logic [31:0] a);
    if (a < 32'd4096) return 0;
    if (a >= TX && a < TX + 32'd16) begin
`ifdef DMEM_TIMER_EN
      return 1;
`else
      return a[3:2] < 2'd2 ? 1 : 2;
`endif
    end
    return 2;
  endfunction
  function automatic logic [31:0] stat_exp();
    return {24'b0, 5'(q.size()), m_ovf, q.size() == 8, q.size() == 0};
  endfunction
  function automatic logic [31:0] read_exp(input logic [31:0] a);
    int r = region(a);
    if (r == 0) return m_ram[a[5:2]];
    if (r == 2) return 32'h0;
    case (a[3:2])
      2'd1: return stat_exp();
      2'd2: return m_time;
      2'd3: return m_cmp;
      default: return 32'h0;
    endcase
  endfunction
  task automatic model_reset();
    q.delete();
    m_ovf = 0;
    m_err = 0;
    m_irq = 0;
    m_time = '0;
    m_cmp = '1;
  endtask
  task automatic model(input logic w, input logic [31:0] a, input logic [31:0] d, input logic rdy);
    int r = region(a);
    bit full_pre = q.size() == 8;
    bit mw = w && r == 1;
    if (r == 2) m_err = 1;
`ifdef DMEM_TIMER_EN
    m_irq = m_time >= m_cmp;
    m_time = (mw && a[3:2] == 2'd2) ? d : m_time + 1;
    if (mw && a[3:2] == 2'd3) m_cmp = d;
`endif
    if (rdy && q.size() != 0) void'(q.pop_front());
    if (mw && a[3:2] == 2'd0) begin
      if (full_pre) m_ovf = 1;
      else q.push_back(d[7:0]);
    end
    if (mw && a[3:2] == 2'd1 && d[2]) m_ovf = 0;
    if (w && r == 0) begin
      m_ram[a[5:2]] = d;
      m_known[a[5:2]] = 1;
    end
  endtask
  task automatic cyc(input logic w, input logic [31:0] a, input logic [31:0] d, input logic rdy);
    bus.MemWrite = w;
    bus.dAddr = a;
    bus.WriteData = d;
    con_ready = rdy;
    #1;
    if (region(a) != 0 || m_known[a[5:2]]) check("rdata", bus.dMemData, read_exp(a));
    check("con_valid", 32'(con_valid), 32'(q.size() != 0));
    check("con_data", 32'(con_data), q.size() != 0 ? 32'(q[0]) : 32'h0);
    check("bus_err", 32'(bus_err), 32'(m_err));
    check("timer_irq", 32'(timer_irq), 32'(m_irq));
    @(posedge clk);
    model(w, a, d, rdy);
    @(negedge clk);
  endtask
  task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.MemWrite = 1'b0;
    bus.dAddr = a;
    #1;
    check(tag, bus.dMemData, exp);
  endtask
  initial begin
    logic [31:0] a;
    int k;
    model_reset();
    bus.MemWrite = 1'b0;
    bus.dAddr = ST;
    bus.WriteData = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_con_valid", 32'(con_valid), 32'h0);
    check("rst_con_data", 32'(con_data), 32'h0);
    check("rst_bus_err", 32'(bus_err), 32'h0);
    check("rst_irq", 32'(timer_irq), 32'h0);
    peek("rst_stat", ST, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 16; i++) cyc(1, 32'(i * 4), $urandom, 0);
    cyc(1, 32'h10, 32'h1234_5678, 0);
    cyc(1, 32'h10, 32'hDEAD_BEEF, 0);
    peek("t1_rd", 32'h10, 32'hDEAD_BEEF);
    cyc(1, TX, 32'h41, 0);
    cyc(1, TX, 32'h42, 0);
    cyc(1, TX, 32'h43, 0);
    peek("t2_level", ST, 32'h18);
    repeat (3) cyc(0, ST, 0, 1);
    check("t2_empty", 32'(con_valid), 32'h0);
    for (int i = 0; i < 9; i++) cyc(1, TX, 32'h30 + 32'(i), 0);
    peek("t3_stat", ST, 32'h46);
    cyc(1, ST, 32'h4, 0);
    peek("t3_clr", ST, 32'h42);
    cyc(1, TX, 32'h5A, 1);
    peek("t4_stat", ST, 32'h3C);
    repeat (7) cyc(0, ST, 0, 1);
    peek("t4_drained", ST, 32'h5);
    cyc(1, ST, 32'h4, 0);
`ifdef DMEM_TIMER_EN
    cyc(1, MC, 32'd100, 0);
    cyc(1, MT, 32'd95, 0);
    repeat (5) cyc(0, ST, 0, 0);
    check("t5_irq_lo", 32'(timer_irq), 32'h0);
    cyc(0, ST, 0, 0);
    check("t5_irq_hi", 32'(timer_irq), 32'h1);
    cyc(1, MT, 32'hFFFF_FFFF, 0);
    cyc(0, ST, 0, 0);
    peek("t5_wrap", MT, 32'h0);
`else
    peek("t5_unmapped", MT, 32'h0);
    cyc(0, MT, 0, 0);
    check("t5_berr", 32'(bus_err), 32'h1);
`endif
    repeat (600) begin
      k = $urandom_range(0, 99);
      a = k < 40 ? {26'd0, 4'($urandom_range(0, 15)), 2'($urandom)} :
          k < 65 ? TX : k < 80 ? ST : k < 90 ? MT : k < 98 ? MC :
          32'h2000_0000 | 32'($urandom_range(0, 255));
      cyc(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3) == 0);
    end
    cyc(0, 32'h2000_0000, 0, 0);
    peek("t6_rd", 32'h2000_0000, 32'h0);
    check("t6_berr", 32'(bus_err), 32'h1);
    cyc(0, ST, 0, 0);
    check("t6_sticky", 32'(bus_err), 32'h1);
    repeat (10) cyc(0, ST, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, TX, 32'h61 + 32'(i), 0);
    cyc(0, ST, 0, 1);
    bus.dAddr = ST;
    reset = 1'b0;
    #1;
    check("t6_rst_valid", 32'(con_valid), 32'h0);
    check("t6_rst_berr", 32'(bus_err), 32'h0);
    check("t6_rst_data", 32'(con_data), 32'h0);
    peek("t6_rst_stat", ST, 32'h1);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (40) begin
      k = $urandom_range(0, 9);
      cyc(1'($urandom_range(0, 1)), k < 6 ? TX : ST, $urandom, $urandom_range(0, 1) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
